// File: rtl/bitnet_pkg.sv
// Shared types and constants for the BitNet FMA lane: sequencer states,
// accumulator limits and the FP4 E3M0 weight field layout.
package bitnet_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int ACC_MIN = -32768;
  localparam int ACC_MAX = 32767;

  localparam int E3M0_SIGN    = 3;
  localparam int E3M0_EXP_MSB = 2;
  localparam int E3M0_EXP_LSB = 0;

endpackage

// File: rtl/bitnet_dot_step.sv
// One saturating multiply-add step: acc +/- (a << exp), clamped to 16 bits.
// An all-zero weight is the only encoding that leaves acc untouched.
import bitnet_pkg::*;

module bitnet_dot_step (
  input  logic [7:0]  a,
  input  logic [3:0]  b,
  input  logic [15:0] acc,
  output logic [15:0] nxt,
  output logic        clamp
);

  logic [15:0] sh;
  logic [16:0] sum;
  int          sum_i;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    nxt   = acc;
    clamp = 1'b0;
    // |a << 7| stays inside 16 bits, so the shifted operand is exact.
    sh    = {{8{a[7]}}, a} << b[E3M0_EXP_MSB:E3M0_EXP_LSB];
    sum   = b[E3M0_SIGN] ? ({acc[15], acc} - {sh[15], sh})
                         : ({acc[15], acc} + {sh[15], sh});
    sum_i = int'($signed(sum));
    if (b != 4'b0000) begin
      if (sum_i > ACC_MAX) begin
        nxt   = 16'(ACC_MAX);
        clamp = 1'b1;
      end else if (sum_i < ACC_MIN) begin
        nxt   = 16'(ACC_MIN);
        clamp = 1'b1;
      end else begin
        nxt   = sum[15:0];
      end
    end
  end

endmodule

// File: rtl/bitnet_dot_seq.sv
// Command/operand sequencer for one BitNet FMA lane: loads the bias, streams
// cmd_len operand beats through the step unit and hands the result downstream.
import bitnet_pkg::*;

module bitnet_dot_seq #(
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [15:0]      cmd_bias,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_sat,
  output logic             busy
);

  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

  state_e           state;
  logic [LEN_W-1:0] cnt;
  logic [15:0]      acc;
  logic             sat;
  logic [15:0]      step_nxt;
  logic             step_clamp;

  bitnet_dot_step u_step (
    .a     (in_a),
    .b     (in_b),
    .acc   (acc),
    .nxt   (step_nxt),
    .clamp (step_clamp)
  );

  // NOTE: registered state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            acc   <= cmd_bias;
            cnt   <= cmd_len;
            sat   <= 1'b0;
            state <= (cmd_len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          // Abort wins over a beat offered in the same cycle.
          if (abort) begin
            state <= IDLE;
          end else if (in_valid) begin
            acc <= step_nxt;
            cnt <= cnt - CNT_ONE;
            sat <= sat | step_clamp;
            if (cnt == CNT_ONE) state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == IDLE);
  assign in_ready  = (state == RUN) && !abort;
  assign out_valid = (state == DONE);
  assign out_data  = acc;
  assign out_sat   = sat;
  assign busy      = (state != IDLE);

endmodule
